// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch. Owns the PC, drives a variable-latency
// imem req/ack port, and hands one registered instruction to the decoder.
module fetch_stage #(
   parameter int                  PC_WIDTH = 32,
   parameter int                  IWIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                f_clk,
   input  logic                f_rst,
   input  logic                f_i_stall,
   input  logic                f_i_change_pc,
   input  logic [PC_WIDTH-1:0] f_i_alu_pc,
   output logic                f_o_imem_req,
   output logic [PC_WIDTH-1:0] f_o_imem_addr,
   input  logic                f_i_imem_ack,
   input  logic [IWIDTH-1:0]   f_i_imem_data,
   output logic [IWIDTH-1:0]   f_o_instr,
   output logic [PC_WIDTH-1:0] f_o_pc,
   output logic                f_o_ce
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SKID = 2'd2;

   logic [1:0]          r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic                r_req;
   logic [PC_WIDTH-1:0] r_addr;
   logic                r_discard;
   logic [IWIDTH-1:0]   r_instr;
   logic [PC_WIDTH-1:0] r_opc;
   logic                r_ce;
   logic [IWIDTH-1:0]   r_sk_instr;
   logic [PC_WIDTH-1:0] r_sk_pc;

   logic [PC_WIDTH-1:0] w_tgt;
   logic [PC_WIDTH-1:0] w_inc;
   logic                w_ack;
   logic                w_free;

   // Redirect target is forced word aligned; pc+4 wraps naturally.
   assign w_tgt  = f_i_alu_pc & ~PC_WIDTH'(3);
   assign w_inc  = r_addr + PC_WIDTH'(4);
   assign w_ack  = r_req & f_i_imem_ack;
   assign w_free = ~r_ce | ~f_i_stall;

   assign f_o_imem_req  = r_req;
   assign f_o_imem_addr = r_addr;
   assign f_o_instr     = r_instr;
   assign f_o_pc        = r_opc;
   assign f_o_ce        = r_ce;

   // Fetch FSM, output register and skid slot; redirect overrides all.
   always_ff @(posedge f_clk or negedge f_rst) begin
      if (!f_rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_discard  <= 1'b0;
         r_instr    <= '0;
         r_opc      <= '0;
         r_ce       <= 1'b0;
         r_sk_instr <= '0;
         r_sk_pc    <= '0;
      end else begin
         if (r_ce && !f_i_stall) begin
            r_ce <= 1'b0;
         end
         if (f_i_change_pc) begin
            r_pc <= w_tgt;
            r_ce <= 1'b0;
            if (r_req && !f_i_imem_ack) begin
               // Keep address stable; the in-flight ack gets dropped.
               r_discard <= 1'b1;
            end else begin
               r_discard <= 1'b0;
               r_req     <= 1'b1;
               r_addr    <= w_tgt;
               r_state   <= S_REQ;
            end
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_req   <= 1'b1;
                  r_addr  <= r_pc;
                  r_state <= S_REQ;
               end
               S_REQ: begin
                  if (w_ack) begin
                     if (r_discard) begin
                        r_discard <= 1'b0;
                        r_addr    <= r_pc;
                     end else if (w_free) begin
                        r_instr <= f_i_imem_data;
                        r_opc   <= r_addr;
                        r_ce    <= 1'b1;
                        r_pc    <= w_inc;
                        r_addr  <= w_inc;
                     end else begin
                        r_sk_instr <= f_i_imem_data;
                        r_sk_pc    <= r_addr;
                        r_req      <= 1'b0;
                        r_pc       <= w_inc;
                        r_state    <= S_SKID;
                     end
                  end
               end
               S_SKID: begin
                  if (!f_i_stall) begin
                     r_instr <= r_sk_instr;
                     r_opc   <= r_sk_pc;
                     r_ce    <= 1'b1;
                     r_req   <= 1'b1;
                     r_addr  <= r_pc;
                     r_state <= S_REQ;
                  end
               end
               default: begin
                  r_req   <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a latency-configurable
// imem model and an in-order scoreboard of delivered PCs.
module tb_fetch_stage;

   logic        f_clk = 1'b0;
   logic        f_rst;
   logic        f_i_stall;
   logic        f_i_change_pc;
   logic [31:0] f_i_alu_pc;
   logic        f_o_imem_req;
   logic [31:0] f_o_imem_addr;
   logic        f_i_imem_ack;
   logic [31:0] f_i_imem_data;
   logic [31:0] f_o_instr;
   logic [31:0] f_o_pc;
   logic        f_o_ce;

   int          n_vec = 0;
   int          n_bad = 0;
   int          lat;
   int          cnt;
   logic        force_ack;
   logic [31:0] sb[$];

   fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'h0)) dut (
      .f_clk(f_clk),
      .f_rst(f_rst),
      .f_i_stall(f_i_stall),
      .f_i_change_pc(f_i_change_pc),
      .f_i_alu_pc(f_i_alu_pc),
      .f_o_imem_req(f_o_imem_req),
      .f_o_imem_addr(f_o_imem_addr),
      .f_i_imem_ack(f_i_imem_ack),
      .f_i_imem_data(f_i_imem_data),
      .f_o_instr(f_o_instr),
      .f_o_pc(f_o_pc),
      .f_o_ce(f_o_ce)
   );

   always #5 f_clk = ~f_clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      case (a)
         32'h0:   memf = 32'h00430820;
         32'h4:   memf = 32'h00A62021;
         default: memf = {a[15:0], ~a[15:0]};
      endcase
   endfunction

   // imem model: ack after lat waiting cycles (lat 0 = same cycle).
   always @(posedge f_clk or negedge f_rst) begin
      if (!f_rst) cnt <= 0;
      else if (f_o_imem_req && !f_i_imem_ack) cnt <= cnt + 1;
      else cnt <= 0;
   end

   assign f_i_imem_ack  = force_ack |
                          (f_o_imem_req && (lat == 0 || cnt == lat));
   assign f_i_imem_data = memf(f_o_imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge f_clk);
      #2;
   endtask

   // Scoreboard: every consumed output must be the next expected PC.
   always @(negedge f_clk) begin
      if (f_rst && f_o_ce && !f_i_stall) begin
         if (sb.size() == 0) begin
            chk("sb_extra", f_o_pc, 32'hDEAD_BEEF);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("sb_pc", f_o_pc, e);
            chk("sb_instr", f_o_instr, memf(e));
         end
      end
   end

   initial begin
      f_rst = 1'b0;
      f_i_stall = 1'b0;
      f_i_change_pc = 1'b0;
      f_i_alu_pc = 32'h0;
      lat = 0;
      force_ack = 1'b0;
      #1;
      chk("rst_req", {31'b0, f_o_imem_req}, 32'h0);
      chk("rst_addr", f_o_imem_addr, 32'h0);
      chk("rst_ce", {31'b0, f_o_ce}, 32'h0);
      chk("rst_pc", f_o_pc, 32'h0);
      chk("rst_instr", f_o_instr, 32'h0);
      tick();
      tick();
      f_rst = 1'b1;
      // streaming with ack tied high
      tick();
      chk("t1_req", {31'b0, f_o_imem_req}, 32'h1);
      chk("t1_addr", f_o_imem_addr, 32'h0);
      chk("t1_ce0", {31'b0, f_o_ce}, 32'h0);
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      sb.push_back(32'h8);
      tick();
      chk("t1_ce", {31'b0, f_o_ce}, 32'h1);
      chk("t1_pc0", f_o_pc, 32'h0);
      chk("t1_i0", f_o_instr, 32'h00430820);
      tick();
      chk("t1_pc4", f_o_pc, 32'h4);
      chk("t1_i4", f_o_instr, 32'h00A62021);
      tick();
      tick();
      // stall three cycles: output frozen, skid fills, req drops
      f_i_stall = 1'b1;
      tick();
      chk("t2_pc", f_o_pc, 32'hC);
      chk("t2_req", {31'b0, f_o_imem_req}, 32'h0);
      chk("t2_ce", {31'b0, f_o_ce}, 32'h1);
      tick();
      tick();
      chk("t2_pc_hold", f_o_pc, 32'hC);
      chk("t2_i_hold", f_o_instr, memf(32'hC));
      f_i_stall = 1'b0;
      sb.push_back(32'hC);
      sb.push_back(32'h10);
      tick();
      tick();
      f_i_stall = 1'b1;
      tick();
      // redirect to 0x8 from skid, then to 0x40 while 0x8 is in flight
      f_i_change_pc = 1'b1;
      f_i_alu_pc = 32'h8;
      lat = 2;
      tick();
      f_i_change_pc = 1'b0;
      f_i_stall = 1'b0;
      chk("t3_addr8", f_o_imem_addr, 32'h8);
      chk("t3_req", {31'b0, f_o_imem_req}, 32'h1);
      chk("t3_ce0", {31'b0, f_o_ce}, 32'h0);
      tick();
      f_i_change_pc = 1'b1;
      f_i_alu_pc = 32'h40;
      tick();
      f_i_change_pc = 1'b0;
      chk("t3_addr_held", f_o_imem_addr, 32'h8);
      chk("t3_ce_drop", {31'b0, f_o_ce}, 32'h0);
      sb.push_back(32'h40);
      tick();
      chk("t3_addr40", f_o_imem_addr, 32'h40);
      chk("t3_ce_none", {31'b0, f_o_ce}, 32'h0);
      tick();
      tick();
      tick();
      chk("t3_pc40", f_o_pc, 32'h40);
      chk("t3_ce1", {31'b0, f_o_ce}, 32'h1);
      tick();
      tick();
      // misaligned redirect in the same cycle as an ack
      f_i_change_pc = 1'b1;
      f_i_alu_pc = 32'h43;
      tick();
      f_i_change_pc = 1'b0;
      chk("t4_addr", f_o_imem_addr, 32'h40);
      chk("t4_ce0", {31'b0, f_o_ce}, 32'h0);
      chk("t4_req", {31'b0, f_o_imem_req}, 32'h1);
      sb.push_back(32'h40);
      tick();
      tick();
      tick();
      chk("t4_pc", f_o_pc, 32'h40);
      lat = 0;
      sb.push_back(32'h44);
      tick();
      tick();
      f_i_stall = 1'b1;
      tick();
      // redirect to the top of the address space and wrap
      f_i_change_pc = 1'b1;
      f_i_alu_pc = 32'hFFFF_FFFC;
      tick();
      f_i_change_pc = 1'b0;
      f_i_stall = 1'b0;
      chk("t5_addr", f_o_imem_addr, 32'hFFFF_FFFC);
      chk("t5_ce0", {31'b0, f_o_ce}, 32'h0);
      sb.push_back(32'hFFFF_FFFC);
      sb.push_back(32'h0);
      tick();
      chk("t5_pc_top", f_o_pc, 32'hFFFF_FFFC);
      chk("t5_addr_wrap", f_o_imem_addr, 32'h0);
      tick();
      chk("t5_pc_wrap", f_o_pc, 32'h0);
      chk("t5_i_wrap", f_o_instr, 32'h00430820);
      tick();
      // reset with a request outstanding
      lat = 2;
      f_i_stall = 1'b1;
      tick();
      chk("t6_pre_pc", f_o_pc, 32'h4);
      f_rst = 1'b0;
      #1;
      chk("t6_req", {31'b0, f_o_imem_req}, 32'h0);
      chk("t6_addr", f_o_imem_addr, 32'h0);
      chk("t6_ce", {31'b0, f_o_ce}, 32'h0);
      chk("t6_pc", f_o_pc, 32'h0);
      chk("t6_instr", f_o_instr, 32'h0);
      f_i_stall = 1'b0;
      tick();
      tick();
      f_rst = 1'b1;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      chk("t6_addr_rel", f_o_imem_addr, 32'h0);
      chk("t6_req_rel", {31'b0, f_o_imem_req}, 32'h1);
      chk("t6_stale", {31'b0, f_o_ce}, 32'h0);
      tick();
      chk("t6_wait", {31'b0, f_o_ce}, 32'h0);
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      tick();
      tick();
      chk("t6_pc0", f_o_pc, 32'h0);
      chk("t6_ce1", {31'b0, f_o_ce}, 32'h1);
      lat = 0;
      tick();
      tick();
      f_i_stall = 1'b1;
      tick();
      tick();
      tick();
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
